// File: rtl/addr_counter_pkg.sv
// Shared constants, types and helpers for the modulo-N address counter.
package addr_counter_pkg;

  localparam int ADDR_WIDTH_DEF = 16;
  localparam int DEPTH_DEF      = 10000;

  typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;

  // Last legal count for a modulus; computed wide so 2**W moduli cannot overflow.
  function automatic longint tc_value(input longint modulus);
    return modulus - 64'sd1;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Generic modulo-N up-counter with a terminal-count flag.
module mod_counter
  import addr_counter_pkg::*;
#(
  parameter int WIDTH   = ADDR_WIDTH_DEF,
  parameter int MODULUS = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(tc_value(longint'(MODULUS)));

  logic [WIDTH-1:0] cnt_d, cnt_q;

  // Next count: wrap at the terminal value; anything beyond it (only reachable
  // by forcing) also loads 0 so the counter self-recovers.
  always_comb begin
    cnt_d = cnt_q + WIDTH'(1);
    if (cnt_q >= TC_VAL) cnt_d = '0;
  end

  // Count register; reset clears it immediately and wins over the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == TC_VAL);

endmodule

// File: rtl/address_counter.sv
// Free-running address generator: 0 .. DEPTH-1, then back to 0, one step per clock.
module address_counter
  import addr_counter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] address
);

  // Reject moduli that cannot be represented or make no sense.
  if (DEPTH < 1 || longint'(DEPTH) > (64'sd1 <<< ADDR_WIDTH)) begin : g_bad_depth
    $error("address_counter: DEPTH must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH");
  end

  logic tc;

  mod_counter #(
    .WIDTH   (ADDR_WIDTH),
    .MODULUS (DEPTH)
  ) u_cnt (
    .clk   (clk),
    .rst_n (reset),
    .cnt   (address),
    .tc    (tc)
  );

  // Address never leaves the legal range.
  a_range: assert property (@(posedge clk) longint'(address) < longint'(DEPTH));

  // Held at 0 while reset is low.
  a_rst: assert property (@(posedge clk) !reset |-> address == '0);

  // Every edge out of reset either increments by one or wraps from the terminal value.
  a_step: assert property (@(posedge clk) disable iff (!reset)
    $past(reset) |-> address == ($past(tc) ? '0 : $past(address) + ADDR_WIDTH'(1)));

endmodule

// File: tb/tb_address_counter.sv
// Scoreboard bench for address_counter: default build plus three parameter corners.
`timescale 1ns/1ps
module tb_address_counter;
  import addr_counter_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  addr_t      addr_main;
  logic [3:0] addr_16;
  logic [3:0] addr_1;
  logic [2:0] addr_5;

  always #5 clk = ~clk;

  address_counter u_main (.clk(clk), .reset(reset), .address(addr_main));
  address_counter #(.ADDR_WIDTH(4), .DEPTH(16)) u_d16 (.clk(clk), .reset(reset), .address(addr_16));
  address_counter #(.ADDR_WIDTH(4), .DEPTH(1))  u_d1  (.clk(clk), .reset(reset), .address(addr_1));
  address_counter #(.ADDR_WIDTH(3), .DEPTH(5))  u_d5  (.clk(clk), .reset(reset), .address(addr_5));

  typedef struct {
    int a_main;
    int a_16;
    int a_1;
    int a_5;
  } exp_t;

  exp_t sb[$];
  int   m_main, m_16, m_1, m_5;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int step(input int v, input int depth);
    return (v >= depth - 1) ? 0 : v + 1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_main"}, addr_main, 0);
    chk({tag, "_d16"},  addr_16,   0);
    chk({tag, "_d1"},   addr_1,    0);
    chk({tag, "_d5"},   addr_5,    0);
  endtask

  // One clock: push the expected post-edge values, then compare on the falling edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    if (reset) begin
      m_main = step(m_main, 10000);
      m_16   = step(m_16, 16);
      m_1    = step(m_1, 1);
      m_5    = step(m_5, 5);
    end else begin
      m_main = 0; m_16 = 0; m_1 = 0; m_5 = 0;
    end
    sb.push_back('{m_main, m_16, m_1, m_5});
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("sb_underflow", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("seq_main", addr_main, e.a_main);
      chk("seq_d16",  addr_16,   e.a_16);
      chk("seq_d1",   addr_1,    e.a_1);
      chk("seq_d5",   addr_5,    e.a_5);
    end
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1 chk_all_zero(tag);
    m_main = 0; m_16 = 0; m_1 = 0; m_5 = 0;
  endtask

  task automatic release_reset(input string tag);
    #1 reset = 1'b1;
    #1 chk_all_zero(tag);
  endtask

  initial begin
    int wrap_idx;
    int prev;
    reset = 1'b0;
    m_main = 0; m_16 = 0; m_1 = 0; m_5 = 0;

    // Reset state and reset hold across three edges
    #2 chk_all_zero("rst_init");
    repeat (3) tick();

    // Release between edges: 0 until next edge, then counting with wrap
    release_reset("rel1");
    wrap_idx = -1;
    prev = 0;
    for (int c = 1; c <= 10003; c++) begin
      tick();
      if (wrap_idx < 0 && addr_main == 0 && prev == 9999) wrap_idx = c;
      prev = int'(addr_main);
    end
    chk("period", wrap_idx, 10000);

    // Asynchronous reset mid-run at 5000
    for (int c = 0; c < 10000 && m_main != 5000; c++) tick();
    chk("at_5000", addr_main, 5000);
    async_reset("mid_rst");
    #3 chk("mid_rst_hold", addr_main, 0);
    release_reset("rel2");
    repeat (20) tick();

    // Reset exactly while at the terminal value
    for (int c = 0; c < 10000 && m_main != 9999; c++) tick();
    chk("at_9999", addr_main, 9999);
    async_reset("tc_rst");
    repeat (2) tick();
    release_reset("rel3");
    tick();
    chk("tc_no_extra", addr_main, 1);
    repeat (40) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/address_counter.md
Name: address_counter

Overview:
- Free-running modulo-N address generator. Produces a sequential read/write address that advances once per clock: 0, 1, …, DEPTH-1, then back to 0.
- Drives memory/frame-buffer address buses elsewhere in the FPGA datapath.
- No enable and no handshake; it counts on every clock edge while out of reset.

Parameters:
- ADDR_WIDTH, 16, width of the address output in bits.
- DEPTH, 10000, number of distinct addresses. Count range is 0 to DEPTH-1.
- Legal range: 1 <= DEPTH <= 2**ADDR_WIDTH. An elaboration-time check must reject illegal values.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. Asserted when 0.
- address  output  ADDR_WIDTH  current address. Registered output, no combinational path from inputs.

Behaviour:
- Reset:
  - reset=0 forces address to 0 immediately, independent of clk.
  - address holds 0 on every clock edge while reset stays low.
- Release: reset is released asynchronously (0→1).
  - address stays 0 until the first rising clk edge after release.
  - At that edge address becomes 1.
  - Net effect: address 0 is visible for the partial cycle before the first post-release edge.
- Counting:
  - On each rising edge with reset=1, address <= address+1 if address < DEPTH-1; otherwise address <= 0.
  - Latency is one cycle per increment, with no gaps.
- Wrap:
  - The value following DEPTH-1 (default 9999) is 0.
  - DEPTH-1 is held for exactly one cycle.
  - The period is exactly DEPTH cycles.
- DEPTH = 2**ADDR_WIDTH: natural binary rollover. The wrap comparison must still be correct and must not overflow any intermediate width.
- DEPTH = 1: address is constantly 0.
- Mid-operation reset: reset going low at any time, including on a clk edge or at DEPTH-1, clears address to 0 with no further increment. Reset wins over the clock.
- Arithmetic:
  - Unsigned arithmetic only.
  - The terminal-count compare uses the constant DEPTH-1, sized to ADDR_WIDTH.
  - Out-of-range values (>= DEPTH) are unreachable from reset. If one is forced, the next edge must load 0.
- No X propagation: address is fully defined from the first reset assertion onward.

Decomposition:
- Shared package addr_counter_pkg:
  - default ADDR_WIDTH and DEPTH constants;
  - an addr_t typedef of logic [ADDR_WIDTH-1:0];
  - a helper function for the terminal-count value.
- One sub-module, mod_counter (generic modulo-N counter with terminal-count flag). address_counter instantiates it with the parameters above and exposes only address.
- Optionally include SVA checks inside address_counter:
  - address < DEPTH at all times;
  - increment-by-one or wrap-to-0 on every edge out of reset;
  - 0 during reset.

Test Plan:
- Reset hold: reset=0 across 3 rising edges -> address=0 throughout. Release at a non-edge time -> address=0 until the next edge, then 1.
- Sequential count: after release, sample on every falling edge for the first 1000 cycles -> values 0, 1, 2, …, 999 in order, zero mismatches.
- Wrap: run 10000+ cycles from release -> 9998, 9999, 0, 1 at the boundary. Period is exactly 10000 cycles; address is never >= 10000.
- Asynchronous mid-run reset: drive reset low between edges while address=5000 -> address=0 immediately, without waiting for clk. Release -> counting restarts from 0.
- Reset at the terminal value: assert reset while address=9999 -> address=0. There is no spurious extra increment after release.
- Parameter corners:
  - ADDR_WIDTH=4, DEPTH=16 -> sequence 0..15 then 0 (binary rollover).
  - DEPTH=1 -> address is always 0.
  - DEPTH=5 -> sequence 0..4 then 0.
